// File: rtl/perf_pkg.sv
// perf_pkg: FSM states and readout index layout shared by the perf_monitor blocks.
package perf_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ARRAY, ARRAY, DONE} state_t;
  localparam int REQ_BASE = 0;
  function automatic int array_idx(input int num_ch);
    return num_ch;
  endfunction
  function automatic int total_idx(input int num_ch);
    return num_ch + 1;
  endfunction
  function automatic int stall_base(input int num_ch);
    return num_ch + 2;
  endfunction
endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: clearable up-counter that holds at all-ones and flags it.
module perf_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 sat
);
  assign sat = &value;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) value <= '0;
    else if (clr) value <= '0;
    else if (inc && !sat) value <= value + CNT_WIDTH'(1);
endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: per-operation request, array-active and total cycle counters with indexed readout.
// Define PERF_MON_STALL_EN to add per-channel stall counters at the upper readout indices.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int CNT_WIDTH = 32,
  parameter int SEL_WIDTH = $clog2(2*NUM_CH+2)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 array_start_i,
  input  logic                 done_i,
  input  logic [NUM_CH-1:0]    req_i,
  input  logic [NUM_CH-1:0]    ack_i,
  input  logic [SEL_WIDTH-1:0] rd_sel_i,
  output logic [CNT_WIDTH-1:0] rd_data_o,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic                 ovf_o
);
  localparam int A_IDX = array_idx(NUM_CH);
  localparam int T_IDX = total_idx(NUM_CH);
  localparam int S_IDX = stall_base(NUM_CH);
`ifdef PERF_MON_STALL_EN
  localparam int NCNT = S_IDX + NUM_CH;
`else
  localparam int NCNT = S_IDX;
`endif
  state_t state, nxt;
  logic [NUM_CH-1:0] req_q;
  logic [NCNT-1:0] inc, sat;
  logic [CNT_WIDTH-1:0] cnt [NCNT];
  logic busy, start_acc;
  assign busy = state == WAIT_ARRAY || state == ARRAY;
  assign start_acc = start_i && (state == IDLE || state == DONE);
  assign inc[REQ_BASE +: NUM_CH] = {NUM_CH{busy}} & req_i & ~req_q;
  assign inc[A_IDX] = state == ARRAY;
  assign inc[T_IDX] = busy;
`ifdef PERF_MON_STALL_EN
  assign inc[S_IDX +: NUM_CH] = {NUM_CH{busy}} & req_i & ~ack_i;
`else
  logic [NUM_CH-1:0] unused_ack;
  assign unused_ack = ack_i;
`endif
  // done_i wins over array_start_i in WAIT_ARRAY so an aborted operation reports zero array cycles
  always_comb nxt = start_acc ? WAIT_ARRAY :
                    busy && done_i ? DONE :
                    state == WAIT_ARRAY && array_start_i ? ARRAY : state;
  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    perf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (start_acc),
      .inc     (inc[g]),
      .value   (cnt[g]),
      .sat     (sat[g])
    );
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      req_q     <= '0;
      rd_data_o <= '0;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      state     <= nxt;
      req_q     <= req_i;
      rd_data_o <= 32'(rd_sel_i) < NCNT ? cnt[rd_sel_i] : '0;
      busy_o    <= nxt == WAIT_ARRAY || nxt == ARRAY;
      valid_o   <= nxt == DONE;
      ovf_o     <= start_acc ? 1'b0 : ovf_o | (|sat);
    end
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: randomized and directed measurement windows scored against a per-window reference model.
module tb_perf_monitor;
  localparam int N = 3;
  localparam int W = 4;
  localparam int S = 3;
  localparam int MAXV = (1 << W) - 1;
  logic clk = 1'b0, reset_n = 1'b0, start_i = 1'b0, array_start_i = 1'b0, done_i = 1'b0;
  logic [N-1:0] req_i = '0, ack_i = '1;
  logic [S-1:0] rd_sel_i = '0;
  logic [W-1:0] rd_data_o;
  logic busy_o, valid_o, ovf_o;
  int errors = 0, checks = 0;
  typedef struct {int sel; int data; bit busy; bit valid; bit ovf;} exp_t;
  exp_t q[$];
  bit rd_req = 1'b0, pend = 1'b0;
  logic [N-1:0] rq [0:63];
  logic [N-1:0] ak [0:63];

  always #5 clk = ~clk;

  perf_monitor #(.NUM_CH(N), .CNT_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .array_start_i(array_start_i),
    .done_i(done_i), .req_i(req_i), .ack_i(ack_i), .rd_sel_i(rd_sel_i),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .valid_o(valid_o), .ovf_o(ovf_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) pend <= rd_req & reset_n;

  always @(negedge clk) begin
    exp_t e;
    if (pend && reset_n) begin
      chk("queue_nonempty", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("rd_data[%0d]", e.sel), 32'(rd_data_o), e.data);
        chk($sformatf("busy@rd%0d", e.sel), 32'(busy_o), 32'(e.busy));
        chk($sformatf("valid@rd%0d", e.sel), 32'(valid_o), 32'(e.valid));
        chk($sformatf("ovf@rd%0d", e.sel), 32'(ovf_o), 32'(e.ovf));
      end
    end
  end

  task automatic step(input bit s, input bit a, input bit d, input logic [N-1:0] r, input logic [N-1:0] k);
    start_i = s; array_start_i = a; done_i = d; req_i = r; ack_i = k;
    @(posedge clk); #1;
  endtask

  task automatic rd(input int sel, input int d, input bit b, input bit v, input bit o);
    exp_t e;
    e.sel = sel; e.data = d; e.busy = b; e.valid = v; e.ovf = o;
    q.push_back(e);
    rd_sel_i = S'(sel); rd_req = 1'b1;
    start_i = 1'b0; array_start_i = 1'b0; done_i = 1'b0; req_i = N'($urandom);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic fill_rand(input int t);
    for (int e = 0; e <= t; e++) begin
      rq[e] = N'($urandom);
      ak[e] = N'($urandom);
    end
  endtask

  task automatic fill_quiet(input int t);
    for (int e = 0; e <= t; e++) begin
      rq[e] = '0;
      ak[e] = '1;
    end
  endtask

  // Window: start sampled at edge 0, done at edge t, array_start at edge wa (may lie beyond t).
  task automatic run_window(input int wa, input int t);
    int raw [8];
    bit ovf;
    step(1'b1, 1'b0, 1'b0, rq[0], ak[0]);
    for (int e = 1; e <= t; e++) begin
      step($urandom_range(0, 3) == 0, e == wa, e == t, rq[e], ak[e]);
      if (e == 1) begin
        chk("busy_in_window", 32'(busy_o), t > 1);
        chk("valid_in_window", 32'(valid_o), t == 1);
      end
    end
    step(1'b0, 1'b0, 1'b0, N'($urandom), '1);
    step(1'b0, 1'b0, 1'b0, N'($urandom), '1);
    foreach (raw[i]) raw[i] = 0;
    raw[N+1] = t;
    raw[N]   = wa < t ? t - wa : 0;
    for (int ch = 0; ch < N; ch++)
      for (int e = 1; e <= t; e++) begin
        if (rq[e][ch] && !rq[e-1][ch]) raw[ch]++;
`ifdef PERF_MON_STALL_EN
        if (rq[e][ch] && !ak[e][ch]) raw[N+2+ch]++;
`endif
      end
    ovf = 1'b0;
    foreach (raw[i]) if (raw[i] >= MAXV) ovf = 1'b1;
    for (int s = 0; s < 2*N+2; s++) rd(s, raw[s] > MAXV ? MAXV : raw[s], 1'b0, 1'b1, ovf);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", 32'(rd_data_o), 0);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_valid", 32'(valid_o), 0);
    chk("reset_ovf", 32'(ovf_o), 0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0, '1);
    for (int s = 0; s < 2*N+2; s++) rd(s, 0, 1'b0, 1'b0, 1'b0);
    // basic window with a req already high at start: a=5, b=7, c=2
    fill_quiet(13);
    rq[0] = 3'b001; rq[1] = 3'b011; rq[2] = 3'b100;
    for (int e = 3; e <= 11; e += 2) rq[e] = 3'b011;
    rq[6] = 3'b100; rq[13] = 3'b010;
    run_window(3, 13);
    // array_start and done together in WAIT_ARRAY
    fill_quiet(4);
    run_window(4, 4);
    // saturating window
    fill_rand(20);
    run_window(2, 20);
    // short follow-up must come back with ovf cleared
    fill_quiet(5);
    run_window(1, 5);
    // c request stalled for 6 busy edges
    fill_quiet(8);
    for (int e = 1; e <= 6; e++) begin
      rq[e] = 3'b100;
      ak[e] = 3'b011;
    end
    run_window(2, 8);
    for (int i = 0; i < 25; i++) begin
      int t = $urandom_range(1, 22);
      fill_rand(t);
      run_window($urandom_range(1, t + 2), t);
    end
    // asynchronous reset in the middle of ARRAY
    fill_rand(8);
    rd_sel_i = S'(N + 1);
    step(1'b1, 1'b0, 1'b0, rq[0], ak[0]);
    for (int e = 1; e <= 6; e++) step(1'b0, e == 2, 1'b0, rq[e], ak[e]);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_rd_data", 32'(rd_data_o), 0);
    chk("midreset_busy", 32'(busy_o), 0);
    chk("midreset_valid", 32'(valid_o), 0);
    chk("midreset_ovf", 32'(ovf_o), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd(N + 1, 0, 1'b0, 1'b0, 1'b0);
    fill_rand(10);
    run_window(3, 10);
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
